// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-side controller: update FIFO, port arbitration, invalidate sweep
// Optional tail coalescing of same-index updates is enabled by BTB_UPD_COALESCE_EN.
module btb_update_ctrl #(
  parameter int ENTRIES    = 32,
  parameter int IDX_W      = 5,
  parameter int TAG_W      = 26,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memory_stall,
  input  logic              flush_all,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  input  logic              upd_taken,
  input  logic              lookup_req,
  output logic              lookup_gnt,
  output logic              fetch_hold,
  output logic              btb_we,
  output logic              btb_wclr,
  output logic [IDX_W-1:0]  btb_widx,
  output logic [TAG_W-1:0]  btb_wtag,
  output logic [31:0]       btb_wtarget,
  output logic              btb_wtaken,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {ST_RST, ST_SWEEP, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sc_q, sc_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [STV_W-1:0] starve_q;

  logic [IDX_W-1:0] mem_idx [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [31:0]      mem_tgt [DEPTH];
  logic             mem_tkn [DEPTH];

  logic             run, empty, full, starved, wr, ready_c, push, enq, coal, mem_we;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [PTR_W-1:0] wr_addr;
  logic             unused_pc0;

  assign upd_idx    = upd_pc[IDX_W:1];
  assign upd_tag    = upd_pc[31:IDX_W+1];
  assign unused_pc0 = upd_pc[0];

  assign run     = (state_q == ST_RUN);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign starved = (starve_q == STV_W'(STARVE_MAX));

  // Writes yield to fetch unless the queue is full or has waited too long.
  assign wr      = run & !empty & !memory_stall & !flush_all &
                   (!lookup_req | full | starved);
  assign ready_c = run & !flush_all & (!full | wr);
  assign push    = upd_valid & ready_c;

`ifdef BTB_UPD_COALESCE_EN
  logic [PTR_W-1:0] tail_ptr;
  assign tail_ptr = wr_ptr_q - PTR_W'(1);
  // A tail that is also the popping head cannot be rewritten; enqueue instead.
  assign coal     = push & !empty & (mem_idx[tail_ptr] == upd_idx) &
                    !(wr & (count_q == CNT_W'(1)));
  assign wr_addr  = coal ? tail_ptr : wr_ptr_q;
`else
  assign coal     = 1'b0;
  assign wr_addr  = wr_ptr_q;
`endif

  assign enq       = push & !coal;
  assign mem_we    = enq | coal;
  assign upd_ready = ready_c;

  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    busy        = 1'b0;
    fetch_hold  = 1'b0;
    lookup_gnt  = 1'b0;
    btb_we      = 1'b0;
    btb_wclr    = 1'b0;
    btb_widx    = '0;
    btb_wtag    = '0;
    btb_wtarget = '0;
    btb_wtaken  = 1'b0;
    case (state_q)
      ST_RST: begin
        busy       = 1'b1;
        fetch_hold = 1'b1;
        state_d    = ST_SWEEP;
        sc_d       = '0;
      end
      ST_SWEEP: begin
        busy       = 1'b1;
        fetch_hold = 1'b1;
        btb_we     = 1'b1;
        btb_wclr   = 1'b1;
        btb_widx   = sc_q;
        if (flush_all) begin
          sc_d = '0;
        end else if (sc_q == IDX_W'(ENTRIES - 1)) begin
          state_d = ST_RUN;
          sc_d    = '0;
        end else begin
          sc_d = sc_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        btb_we      = wr;
        btb_widx    = mem_idx[rd_ptr_q];
        btb_wtag    = mem_tag[rd_ptr_q];
        btb_wtarget = mem_tgt[rd_ptr_q];
        btb_wtaken  = mem_tkn[rd_ptr_q];
        lookup_gnt  = !wr;
        fetch_hold  = wr & lookup_req;
        if (flush_all) begin
          state_d = ST_SWEEP;
          sc_d    = '0;
        end
      end
      default: begin
        state_d = ST_RST;
        sc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RST;
      sc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      if (flush_all) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        starve_q <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (wr)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(enq) - CNT_W'(wr);
        if (wr || empty)
          starve_q <= '0;
        else if (!memory_stall && !starved)
          starve_q <= starve_q + STV_W'(1);
      end
    end
  end

  // Payload storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_idx[wr_addr] <= upd_idx;
      mem_tag[wr_addr] <= upd_tag;
      mem_tgt[wr_addr] <= upd_target;
      mem_tkn[wr_addr] <= upd_taken;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed scoreboard bench for btb_update_ctrl
module tb_btb_update_ctrl;

  logic        clk, rst_n, memory_stall, flush_all;
  logic        upd_valid, upd_ready, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic        lookup_req, lookup_gnt, fetch_hold;
  logic        btb_we, btb_wclr, btb_wtaken, busy;
  logic [4:0]  btb_widx;
  logic [25:0] btb_wtag;
  logic [31:0] btb_wtarget;

  btb_update_ctrl dut (
    .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall), .flush_all(flush_all),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .lookup_req(lookup_req),
    .lookup_gnt(lookup_gnt), .fetch_hold(fetch_hold), .btb_we(btb_we),
    .btb_wclr(btb_wclr), .btb_widx(btb_widx), .btb_wtag(btb_wtag),
    .btb_wtarget(btb_wtarget), .btb_wtaken(btb_wtaken), .busy(busy)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [25:0] tag;
    logic [31:0] tgt;
    logic        tkn;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   run_writes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn);
    exp_t e;
    e.idx = pc[5:1];
    e.tag = pc[31:6];
    e.tgt = tgt;
    e.tkn = tkn;
    return e;
  endfunction

  // Offers one update for a cycle; the expected write is queued when it should be accepted.
  task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn,
                      input bit track);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tkn;
    #1;
    chk("upd_ready", 32'(upd_ready), 32'd1);
    if (track) sb.push_back(mk(pc, tgt, tkn));
    tick();
    upd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && btb_we && !btb_wclr) begin
      run_writes++;
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_idx", 32'(btb_widx), 32'(e.idx));
        chk("wr_tag", 32'(btb_wtag), 32'(e.tag));
        chk("wr_target", btb_wtarget, e.tgt);
        chk("wr_taken", 32'(btb_wtaken), 32'(e.tkn));
      end
    end
  end

  initial begin
    int wbase;
    rst_n = 1'b0; memory_stall = 1'b0; flush_all = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; lookup_req = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_hold", 32'(fetch_hold), 32'd1);
    chk("rst_we", 32'(btb_we), 32'd0);
    chk("rst_gnt", 32'(lookup_gnt), 32'd0);
    chk("rst_ready", 32'(upd_ready), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Post-reset invalidate sweep
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("sweep_we", 32'({btb_we, btb_wclr}), 32'd3);
      chk("sweep_idx", 32'(btb_widx), 32'(i));
      chk("sweep_busy", 32'({busy, fetch_hold, upd_ready}), 32'b110);
    end
    tick();
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_gnt", 32'(lookup_gnt), 32'd1);

    // Single update with fetch idle: write on the next cycle
    send(32'h0000_1234, 32'h0000_2000, 1'b1, 1'b1);
    chk("lat1_we", 32'(btb_we), 32'd1);
    chk("lat1_idx", 32'(btb_widx), 32'h1A);
    chk("lat1_tag", 32'(btb_wtag), 32'h48);
    tick();
    chk("lat1_idle", 32'(btb_we), 32'd0);

    // Fill with fetch busy; full queue forces a write while still accepting
    lookup_req = 1'b1;
    send(32'h100, 32'hA0, 1'b0, 1'b1);
    send(32'h204, 32'hA1, 1'b1, 1'b1);
    send(32'h308, 32'hA2, 1'b0, 1'b1);
    send(32'h40C, 32'hA3, 1'b1, 1'b1);
    upd_valid = 1'b1; upd_pc = 32'h510; upd_target = 32'hA4; upd_taken = 1'b1;
    #1;
    chk("full_we", 32'(btb_we), 32'd1);
    chk("full_gnt", 32'(lookup_gnt), 32'd0);
    chk("full_hold", 32'(fetch_hold), 32'd1);
    chk("full_ready", 32'(upd_ready), 32'd1);
    sb.push_back(mk(32'h510, 32'hA4, 1'b1));
    tick();
    upd_valid = 1'b0;
    #1;
    chk("full2_we", 32'(btb_we), 32'd1);
    lookup_req = 1'b0;
    repeat (6) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);

    // Starvation: eight deferred cycles, then a forced write
    lookup_req = 1'b1;
    send(32'h600, 32'hB0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("starve_wait", 32'(btb_we), 32'd0);
      tick();
    end
    chk("starve_we", 32'(btb_we), 32'd1);
    chk("starve_hold", 32'(fetch_hold), 32'd1);
    tick();

    // Flush discards queued updates and reruns the sweep
    send(32'h700, 32'hC0, 1'b0, 1'b0);
    send(32'h704, 32'hC1, 1'b0, 1'b0);
    send(32'h708, 32'hC2, 1'b0, 1'b0);
    flush_all = 1'b1;
    #1;
    chk("flush_we", 32'(btb_we), 32'd0);
    chk("flush_ready", 32'(upd_ready), 32'd0);
    tick();
    flush_all = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("fsweep", 32'({btb_we, btb_wclr, btb_widx}), 32'({2'b11, 5'(i)}));
      tick();
    end
    chk("fsweep_done", 32'(busy), 32'd0);
    lookup_req = 1'b0;
    wbase = run_writes;
    repeat (3) tick();
    chk("flush_discard", 32'(run_writes - wbase), 32'd0);

    // Stalled updates to the same index
    memory_stall = 1'b1;
    send(32'h0000_1234, 32'h0000_2000, 1'b1, 1'b0);
    send(32'h0000_1234, 32'h0000_3000, 1'b1, 1'b0);
    chk("stall_we", 32'(btb_we), 32'd0);
`ifdef BTB_UPD_COALESCE_EN
    sb.push_back(mk(32'h0000_1234, 32'h0000_3000, 1'b1));
`else
    sb.push_back(mk(32'h0000_1234, 32'h0000_2000, 1'b1));
    sb.push_back(mk(32'h0000_1234, 32'h0000_3000, 1'b1));
`endif
    wbase = run_writes;
    tick();
    chk("stall_hold", 32'(run_writes - wbase), 32'd0);
    memory_stall = 1'b0;
    repeat (4) tick();
`ifdef BTB_UPD_COALESCE_EN
    chk("coalesce_writes", 32'(run_writes - wbase), 32'd1);
`else
    chk("coalesce_writes", 32'(run_writes - wbase), 32'd2);
`endif

    // Asynchronous reset with an update pending
    lookup_req = 1'b1;
    send(32'h800, 32'hD0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_busy", 32'({busy, fetch_hold, btb_we}), 32'b110);
    tick();
    rst_n = 1'b1;
    repeat (33) tick();
    chk("areset_run", 32'(busy), 32'd0);
    lookup_req = 1'b0;
    wbase = run_writes;
    repeat (3) tick();
    chk("areset_discard", 32'(run_writes - wbase), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
